uart_cmd_master: RTL and testbench

Command-issuing end of the LED/control UART link. Accepts a command request and serializes the matching command byte on tx (8 data bits, optional parity, 1 stop bit). For link commands, it then waits for the 0x6B acknowledge byte from an external uart_rx. Reports each command with a one-cycle done or fail pulse. Sits in the master FPGA next to a uart_rx instance and drives the slave boards' rx line.

---
 rtl/uart_cmd_master_if.sv | 22 ++
 rtl/uart_cmd_master.sv | 193 +++++++++++++++++++
 tb/tb_uart_cmd_master.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_master_if.sv
// Command request, serial tx line and ack/result signals of uart_cmd_master.
// The master modport is the uart_cmd_master side; slave is the requester/test side.
interface uart_cmd_master_if;
    logic       cmd_valid;
    logic [1:0] cmd_sel;
    logic       cmd_ready;
    logic       tx;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       done;
    logic       fail;

    modport master (
        input  cmd_valid, cmd_sel, rx_done, rx_data,
        output cmd_ready, tx, done, fail
    );

    modport slave (
        output cmd_valid, cmd_sel, rx_done, rx_data,
        input  cmd_ready, tx, done, fail
    );
endinterface

// File: rtl/uart_cmd_master.sv
// Serializes LED/control command bytes on tx and waits for the 0x6B ack from uart_rx.
// Optional macro CMD_RETRY_EN: on ack timeout retransmit up to MAX_RETRIES times before fail.
module uart_cmd_master #(
    parameter int unsigned BAUD_RATE   = 4,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned ACK_TIMEOUT = 2400,
    parameter int unsigned MAX_RETRIES = 3
) (
    input logic               clk,
    input logic               reset,
    uart_cmd_master_if.master bus
);

    localparam int unsigned BaudW    = (BAUD_RATE > 1) ? $clog2(BAUD_RATE) : 1;
    localparam int unsigned ToW      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_RATE - 1);
    localparam logic [ToW-1:0]   ToLast   = ToW'(ACK_TIMEOUT - 1);
    localparam logic [7:0]       AckByte  = 8'h6B;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop,
        StWaitAck
    } state_e;

    state_e           state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [ToW-1:0]   to_q, to_d;
    logic [7:0]       data_q, data_d;
    logic             ack_cmd_q, ack_cmd_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic [7:0]       cmd_byte;
    logic             baud_end;
    logic             tx;

`ifdef CMD_RETRY_EN
    localparam int unsigned RetryW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRIES);

    logic [RetryW-1:0] retry_q, retry_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    always_comb begin
        unique case (bus.cmd_sel)
            2'd0: cmd_byte = 8'h2A;
            2'd1: cmd_byte = 8'h93;
            2'd2: cmd_byte = 8'hC3;
            2'd3: cmd_byte = AckByte;
        endcase
    end

    assign baud_end = (baud_q == BaudLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_q     <= '0;
            to_q      <= '0;
            data_q    <= '0;
            ack_cmd_q <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            to_q      <= to_d;
            data_q    <= data_d;
            ack_cmd_q <= ack_cmd_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        to_d      = to_q;
        data_d    = data_q;
        ack_cmd_d = ack_cmd_q;
        done_d    = 1'b0;
        fail_d    = 1'b0;
`ifdef CMD_RETRY_EN
        retry_d   = retry_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    data_d    = cmd_byte;
                    ack_cmd_d = (bus.cmd_sel == 2'd3);
                    baud_d    = '0;
                    bit_d     = '0;
`ifdef CMD_RETRY_EN
                    retry_d   = '0;
`endif
                    state_d   = StStart;
                end
            end
            StStart: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY != 0) ? StPar : StStop;
                    end
                end
            end
            StPar: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    // The ack byte itself is never acknowledged by the far end.
                    if (ack_cmd_q) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        to_d    = '0;
                        state_d = StWaitAck;
                    end
                end
            end
            StWaitAck: begin
                to_d = to_q + 1'b1;
                // Ack is checked first so it wins over a coincident timeout.
                if (bus.rx_done && (bus.rx_data == AckByte)) begin
                    to_d    = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (to_q == ToLast) begin
                    to_d = '0;
`ifdef CMD_RETRY_EN
                    if (retry_q < RetryMax) begin
                        retry_d = retry_q + 1'b1;
                        baud_d  = '0;
                        bit_d   = '0;
                        state_d = StStart;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = StIdle;
                    end
`else
                    fail_d  = 1'b1;
                    state_d = StIdle;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        unique case (state_q)
            StStart: tx = 1'b0;
            StData:  tx = data_q[bit_q];
            StPar:   tx = ^data_q;
            default: tx = 1'b1;
        endcase
    end

    assign bus.tx        = tx;
    assign bus.cmd_ready = (state_q == StIdle) && !reset;
    assign bus.done      = done_q;
    assign bus.fail      = fail_q;

endmodule

// File: tb/tb_uart_cmd_master.sv
// Drives two uart_cmd_master instances (no parity / even parity) with the same stimulus and
// compares every cycle against a frame-timeline reference model.
module tb_uart_cmd_master;

    localparam int B  = 4;
    localparam int TO = 100;
    localparam int R  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_sel = 2'd0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;

    int n_assert = 0;
    int n_fail   = 0;

    uart_cmd_master_if ifa ();
    uart_cmd_master_if ifb ();

    assign ifa.cmd_valid = cmd_valid;
    assign ifa.cmd_sel   = cmd_sel;
    assign ifa.rx_done   = rx_done;
    assign ifa.rx_data   = rx_data;
    assign ifb.cmd_valid = cmd_valid;
    assign ifb.cmd_sel   = cmd_sel;
    assign ifb.rx_done   = rx_done;
    assign ifb.rx_data   = rx_data;

    uart_cmd_master #(
        .BAUD_RATE(B), .PARITY(0), .ACK_TIMEOUT(TO), .MAX_RETRIES(R)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.master)
    );

    uart_cmd_master #(
        .BAUD_RATE(B), .PARITY(1), .ACK_TIMEOUT(TO), .MAX_RETRIES(R)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.master)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] byte_of(input int sel);
        logic [7:0] tbl [4];
        tbl[0] = 8'h2A;
        tbl[1] = 8'h93;
        tbl[2] = 8'hC3;
        tbl[3] = 8'h6B;
        return tbl[sel];
    endfunction

    // Offset k counts cycles after the accepting edge (k=1 is the first START cycle).
    function automatic void predict(input int sel, input int p, input int ack_off,
                                    output int end_off, output bit is_fail);
        int flen, per, n_att, ws;
        flen    = (10 + p) * B;
        per     = flen + TO;
        is_fail = 1'b0;
        if (sel == 3) begin
            end_off = 1 + flen;
            return;
        end
`ifdef CMD_RETRY_EN
        n_att = 1 + R;
`else
        n_att = 1;
`endif
        for (int n = 0; n < n_att; n++) begin
            ws = 1 + n * per + flen;
            if (ack_off >= ws && ack_off <= ws + TO - 1) begin
                end_off = ack_off + 1;
                return;
            end
        end
        end_off = 1 + n_att * per;
        is_fail = 1'b1;
    endfunction

    function automatic logic exp_tx(input logic [7:0] data, input int p, input int k,
                                    input int end_off);
        int flen, per, m, pos;
        if (k >= end_off) return 1'b1;
        flen = (10 + p) * B;
        per  = flen + TO;
        m    = (k - 1) % per;
        if (m >= flen) return 1'b1;
        pos = m / B;
        if (pos == 0) return 1'b0;
        if (pos <= 8) return data[pos-1];
        if (p != 0 && pos == 9) return ^data;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_quiet(input string tag, input logic tx_e, input logic rdy_e);
        check({tag, "_tx_a"}, {7'd0, ifa.tx}, {7'd0, tx_e});
        check({tag, "_tx_b"}, {7'd0, ifb.tx}, {7'd0, tx_e});
        check({tag, "_rdy_a"}, {7'd0, ifa.cmd_ready}, {7'd0, rdy_e});
        check({tag, "_rdy_b"}, {7'd0, ifb.cmd_ready}, {7'd0, rdy_e});
        check({tag, "_pulse_a"}, {6'd0, ifa.done, ifa.fail}, 8'd0);
        check({tag, "_pulse_b"}, {6'd0, ifb.done, ifb.fail}, 8'd0);
    endtask

    // Starts and ends just after a negedge; poke_off re-pulses cmd_valid while busy.
    task automatic run_cmd(input int sel, input int ack_off, input int junk_off,
                           input int poke_off);
        logic [7:0] data;
        int         end_off [2];
        bit         is_fail [2];
        int         last;
        logic       o_tx, o_rdy, o_done, o_fail;
        data = byte_of(sel);
        for (int i = 0; i < 2; i++) predict(sel, i, ack_off, end_off[i], is_fail[i]);
        last = ((end_off[0] > end_off[1]) ? end_off[0] : end_off[1]) + 1;
        check($sformatf("ready_a_pre_sel%0d", sel), {7'd0, ifa.cmd_ready}, 8'd1);
        check($sformatf("ready_b_pre_sel%0d", sel), {7'd0, ifb.cmd_ready}, 8'd1);
        cmd_sel   = 2'(sel);
        cmd_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                o_tx   = (i == 0) ? ifa.tx : ifb.tx;
                o_rdy  = (i == 0) ? ifa.cmd_ready : ifb.cmd_ready;
                o_done = (i == 0) ? ifa.done : ifb.done;
                o_fail = (i == 0) ? ifa.fail : ifb.fail;
                check($sformatf("tx_p%0d_sel%0d_k%0d", i, sel, k), {7'd0, o_tx},
                      {7'd0, exp_tx(data, i, k, end_off[i])});
                check($sformatf("ready_p%0d_sel%0d_k%0d", i, sel, k), {7'd0, o_rdy},
                      {7'd0, (k >= end_off[i])});
                check($sformatf("done_p%0d_sel%0d_k%0d", i, sel, k), {7'd0, o_done},
                      {7'd0, (k == end_off[i]) && !is_fail[i]});
                check($sformatf("fail_p%0d_sel%0d_k%0d", i, sel, k), {7'd0, o_fail},
                      {7'd0, (k == end_off[i]) && is_fail[i]});
            end
            cmd_valid = (k == poke_off);
            if (k == poke_off) cmd_sel = 2'($urandom_range(0, 3));
            rx_done = (k == ack_off) || (k == junk_off);
            rx_data = (k == ack_off) ? 8'h6B : 8'h55;
        end
        cmd_valid = 1'b0;
        rx_done   = 1'b0;
    endtask

    initial begin
        int sel, ack, junk, poke, span;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("in_reset", 1'b1, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_quiet("after_reset", 1'b1, 1'b1);

        // turn_on, ack 10 cycles after the parity frame's stop bit
        run_cmd(0, 55, -1, -1);
        // turn_off, random ack inside both windows, junk byte and busy request
        run_cmd(1, $urandom_range(45, 140), 30, 6);
        // ack command: no ack awaited, late rx_done ignored
        run_cmd(3, -1, 45, -1);
        // no ack at all -> retries then fail
        run_cmd(0, -1, -1, -1);
        // ack byte while still transmitting is ignored
        run_cmd(2, 20, -1, 8);
        // ack at the timeout terminal cycle (no-parity, then parity instance)
        run_cmd(1, 140, 139, -1);
        run_cmd(1, 144, 143, -1);

        // Reset in the middle of the 0xC3 data bits
        cmd_sel   = 2'd2;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_quiet("mid_reset", 1'b1, 1'b0);
        @(negedge clk);
        check_quiet("mid_reset_hold", 1'b1, 1'b0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_quiet("post_reset_idle", 1'b1, 1'b1);
        end
        run_cmd(2, 60, 50, 10);

        // Random commands
`ifdef CMD_RETRY_EN
        span = (1 + R) * (44 + TO) + 5;
`else
        span = 44 + TO + 5;
`endif
        for (int n = 0; n < 8; n++) begin
            sel  = $urandom_range(0, 3);
            ack  = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(1, span);
            junk = $urandom_range(1, span);
            poke = $urandom_range(2, 30);
            run_cmd(sel, ack, junk, poke);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
